mfu_host_ctrl: RTL
==================

MFU_HOST_CTRL -- requirements
Module: mfu_host_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of the median-filter-unit data bus.
REQ-002 SHALL have parameter ADDR_W, default 18, meaning the pixel/register offset width.
REQ-003 SHALL have parameter MODE_W, default 2, meaning the region-select field width; the full address is {mode, offset}.
REQ-004 SHALL have parameter RD_LAT, default 2, meaning cycles from a read issue (ena=1, we=0) until mfu_douta_i is valid.
REQ-005 SHALL have ports: CLK in 1, the single clock; RST in 1, synchronous active-high reset.
REQ-006 SHALL have ports: start_i in 1, a start pulse; width_i in 16 and height_i in 16, the image dimensions sampled at start.
REQ-007 SHALL have ports: s_data_i in 8, s_valid_i in 1, s_ready_o out 1, the noisy-pixel input stream (raster order).
REQ-008 SHALL have ports: m_data_o out 8, m_valid_o out 1, m_ready_i in 1, the filtered-pixel output stream.
REQ-009 SHALL have ports: busy_o out 1, done_o out 1 (one-cycle pulse), err_o out 1.
REQ-010 SHALL have ports: mfu_dina_o out DATA_W, mfu_addra_o out MODE_W+ADDR_W, mfu_wea_o out 1, mfu_ena_o out 1, mfu_douta_i in DATA_W.

Function
REQ-011 SHALL use this region map: mode 0 = image memory; mode 1 = control/status (write 1 = start, read 1 = finished); mode 2 = width; mode 3 = height.
REQ-012 SHALL implement the FSM IDLE->LOAD->CFG_W->CFG_H->GO->POLL->DRAIN->FIN->IDLE.
REQ-013 SHALL, in IDLE, latch width_i/height_i on start_i and compute N = width*height.
REQ-014 SHALL go from IDLE straight to FIN when N==0 or N>2^ADDR_W, with err_o=1 and no memory transaction.
REQ-015 SHALL, in LOAD, hold s_ready_o=1 and, for each s_valid_i&s_ready_o beat, issue one write {0,k} (k=0..N-1) with dina={24'b0,s_data_i} in the same cycle; it SHALL move to CFG_W after beat N-1.
REQ-016 SHALL use one write cycle each in CFG_W, CFG_H and GO: {2,0}<=width, {3,0}<=height, {1,0}<=1.
REQ-017 SHALL, in POLL, issue a read of {1,0}, wait RD_LAT cycles, and go to DRAIN if mfu_douta_i==1, otherwise re-issue; at most one poll read SHALL be outstanding.
REQ-018 SHALL, in DRAIN, issue reads {0,k} for k=0..N-1 and push mfu_douta_i[7:0] into an internal FIFO of depth RD_LAT+2 that feeds m_data_o/m_valid_o.
REQ-019 SHALL issue a read only when FIFO occupancy plus in-flight reads < RD_LAT+2, so no data is lost under m_ready_i=0; sustained throughput SHALL be 1 pixel/cycle when m_ready_i=1.
REQ-020 SHALL leave DRAIN for FIN only after all N pixels have been accepted on the output; FIN SHALL pulse done_o for one cycle and return to IDLE.
REQ-021 SHALL hold busy_o=1 in every state except IDLE, and SHALL ignore start_i while busy_o=1.
REQ-022 SHALL drive mfu_ena_o=0, mfu_wea_o=0 and s_ready_o=0 outside LOAD whenever no transaction is issued.
REQ-023 SHALL clear err_o on the next accepted start_i.

Reset
REQ-024 SHALL, on RST=1 at a CLK edge, enter IDLE, flush the FIFO and drop in-flight reads.
REQ-025 SHALL, on reset, set all outputs to 0 (s_ready_o, m_valid_o, busy_o, done_o, err_o, mfu_* all 0), including when reset arrives mid-LOAD or mid-DRAIN.

Configuration
REQ-026 SHALL support the macro MFU_POLL_TIMEOUT_EN.
REQ-027 SHALL, when MFU_POLL_TIMEOUT_EN is defined, count POLL cycles against a 32-bit timeout parameter POLL_TIMEOUT (default 1,000,000) and, on expiry, go to FIN with err_o=1 and skip DRAIN.
REQ-028 SHALL, when MFU_POLL_TIMEOUT_EN is undefined, poll indefinitely with err_o driven only by REQ-014.

Verification
REQ-029 SHALL cover: width=430, height=554, 238220 random pixels, model done after 500 cycles -> writes to {0,0..238219}, then {2,0}=430, {3,0}=554, {1,0}=1; output stream equals the model's filtered image; single done_o.
REQ-030 SHALL cover: width=4, height=4, m_ready_i toggling 1-0-0-1 -> 16 pixels in order, no loss or duplication, FIFO never exceeds RD_LAT+2.
REQ-031 SHALL cover: width=0, height=5 -> done_o after 1 cycle, err_o=1, mfu_ena_o never asserted.
REQ-032 SHALL cover: RST=1 asserted at pixel 100 of LOAD -> all outputs 0 next cycle; a new start then restarts at address {0,0}.
REQ-033 SHALL cover: with MFU_POLL_TIMEOUT_EN and POLL_TIMEOUT=50 while status stays 0 -> done_o and err_o=1 about 50 cycles after GO, no DRAIN reads.
REQ-034 SHALL cover: start_i pulsed during DRAIN -> ignored, and the current image completes normally.

Source files
------------

// File: rtl/mfu_host_ctrl.sv
// Host-side controller for a median-filter unit: loads an image, configures and starts the unit,
// polls for completion and streams the filtered image out. Optional macro: MFU_POLL_TIMEOUT_EN.
module mfu_host_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 18,
    parameter int MODE_W = 2,
    parameter int RD_LAT = 2
`ifdef MFU_POLL_TIMEOUT_EN
    ,
    parameter logic [31:0] POLL_TIMEOUT = 32'd1000000
`endif
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     start_i,
    input  logic [15:0]              width_i,
    input  logic [15:0]              height_i,
    input  logic [7:0]               s_data_i,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    output logic [7:0]               m_data_o,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [DATA_W-1:0]        mfu_dina_o,
    output logic [MODE_W+ADDR_W-1:0] mfu_addra_o,
    output logic                     mfu_wea_o,
    output logic                     mfu_ena_o,
    input  logic [DATA_W-1:0]        mfu_douta_i
);
    localparam int DEPTH = RD_LAT + 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int K_W   = ADDR_W + 1;
    localparam logic [32:0] N_MAX = 33'd1 << ADDR_W;

    localparam logic [MODE_W-1:0] MODE_MEM  = MODE_W'(0);
    localparam logic [MODE_W-1:0] MODE_CTRL = MODE_W'(1);
    localparam logic [MODE_W-1:0] MODE_WID  = MODE_W'(2);
    localparam logic [MODE_W-1:0] MODE_HGT  = MODE_W'(3);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CFG_W, S_CFG_H, S_GO, S_POLL, S_DRAIN, S_FIN
    } state_t;

    state_t             r_state;
    logic [15:0]        r_width;
    logic [15:0]        r_height;
    logic [K_W-1:0]     r_n;
    logic [K_W-1:0]     r_k;
    logic [K_W-1:0]     r_out_cnt;
    logic               r_err;
    logic               r_poll_pend;
    logic [RD_LAT-1:0]  r_pipe;
    logic [7:0]         r_fifo [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
`ifdef MFU_POLL_TIMEOUT_EN
    logic [31:0]        r_to_cnt;
`endif

    logic [31:0]        w_n_full;
    logic               w_n_bad;
    logic [CNT_W:0]     w_inflight;
    logic               w_rd_issue;
    logic               w_poll_issue;
    logic               w_rd_valid;
    logic               w_push;
    logic               w_pop;
    logic               w_last_out;
    logic [RD_LAT-1:0]  w_pipe_next;

    assign w_n_full     = {16'd0, width_i} * {16'd0, height_i};
    assign w_n_bad      = (w_n_full == 32'd0) || ({1'b0, w_n_full} > N_MAX);
    assign w_rd_valid   = r_pipe[RD_LAT-1];
    assign w_push       = w_rd_valid && (r_state == S_DRAIN);
    assign w_pop        = m_valid_o && m_ready_i;
    assign w_last_out   = w_pop && (r_out_cnt == r_n - K_W'(1));
    assign w_poll_issue = (r_state == S_POLL) && !r_poll_pend;
    // Reads are only issued when the FIFO is guaranteed a slot for every returning word.
    assign w_rd_issue   = (r_state == S_DRAIN) && (r_k < r_n) &&
                          (({1'b0, r_count} + w_inflight) < (CNT_W+1)'(DEPTH));

    assign s_ready_o = (r_state == S_LOAD);
    assign busy_o    = (r_state != S_IDLE);
    assign done_o    = (r_state == S_FIN);
    assign err_o     = r_err;
    assign m_valid_o = (r_count != '0);
    assign m_data_o  = m_valid_o ? r_fifo[r_rd_ptr] : 8'd0;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + (CNT_W+1)'(r_pipe[i]);
        end
        w_pipe_next    = r_pipe << 1;
        w_pipe_next[0] = w_rd_issue || w_poll_issue;
    end

    always_comb begin
        mfu_ena_o   = 1'b0;
        mfu_wea_o   = 1'b0;
        mfu_addra_o = '0;
        mfu_dina_o  = '0;
        case (r_state)
            S_LOAD: if (s_valid_i) begin
                mfu_ena_o   = 1'b1;
                mfu_wea_o   = 1'b1;
                mfu_addra_o = {MODE_MEM, r_k[ADDR_W-1:0]};
                mfu_dina_o  = DATA_W'(s_data_i);
            end
            S_CFG_W: begin
                mfu_ena_o   = 1'b1;
                mfu_wea_o   = 1'b1;
                mfu_addra_o = {MODE_WID, ADDR_W'(0)};
                mfu_dina_o  = DATA_W'(r_width);
            end
            S_CFG_H: begin
                mfu_ena_o   = 1'b1;
                mfu_wea_o   = 1'b1;
                mfu_addra_o = {MODE_HGT, ADDR_W'(0)};
                mfu_dina_o  = DATA_W'(r_height);
            end
            S_GO: begin
                mfu_ena_o   = 1'b1;
                mfu_wea_o   = 1'b1;
                mfu_addra_o = {MODE_CTRL, ADDR_W'(0)};
                mfu_dina_o  = DATA_W'(1);
            end
            S_POLL: if (w_poll_issue) begin
                mfu_ena_o   = 1'b1;
                mfu_addra_o = {MODE_CTRL, ADDR_W'(0)};
            end
            S_DRAIN: if (w_rd_issue) begin
                mfu_ena_o   = 1'b1;
                mfu_addra_o = {MODE_MEM, r_k[ADDR_W-1:0]};
            end
            default: ;
        endcase
    end

    // FIFO storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= mfu_douta_i[7:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pipe   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_pipe <= w_pipe_next;
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH-1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH-1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_width     <= '0;
            r_height    <= '0;
            r_n         <= '0;
            r_k         <= '0;
            r_out_cnt   <= '0;
            r_err       <= 1'b0;
            r_poll_pend <= 1'b0;
`ifdef MFU_POLL_TIMEOUT_EN
            r_to_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (start_i) begin
                    r_width  <= width_i;
                    r_height <= height_i;
                    r_n      <= K_W'(w_n_full);
                    r_k      <= '0;
                    r_err    <= w_n_bad;
                    r_state  <= w_n_bad ? S_FIN : S_LOAD;
                end
                S_LOAD: if (s_valid_i) begin
                    if (r_k == r_n - K_W'(1)) begin
                        r_k     <= '0;
                        r_state <= S_CFG_W;
                    end else begin
                        r_k <= r_k + K_W'(1);
                    end
                end
                S_CFG_W: r_state <= S_CFG_H;
                S_CFG_H: r_state <= S_GO;
                S_GO: begin
                    r_poll_pend <= 1'b0;
`ifdef MFU_POLL_TIMEOUT_EN
                    r_to_cnt    <= '0;
`endif
                    r_state     <= S_POLL;
                end
                S_POLL: begin
                    if (w_poll_issue) begin
                        r_poll_pend <= 1'b1;
                    end else if (w_rd_valid) begin
                        r_poll_pend <= 1'b0;
                        if (mfu_douta_i == DATA_W'(1)) begin
                            r_k       <= '0;
                            r_out_cnt <= '0;
                            r_state   <= S_DRAIN;
                        end
                    end
`ifdef MFU_POLL_TIMEOUT_EN
                    if (r_to_cnt == POLL_TIMEOUT - 32'd1) begin
                        r_poll_pend <= 1'b0;
                        r_err       <= 1'b1;
                        r_state     <= S_FIN;
                    end else begin
                        r_to_cnt <= r_to_cnt + 32'd1;
                    end
`endif
                end
                S_DRAIN: begin
                    if (w_rd_issue) begin
                        r_k <= r_k + K_W'(1);
                    end
                    if (w_pop) begin
                        r_out_cnt <= r_out_cnt + K_W'(1);
                    end
                    if (w_last_out) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
